// File: rtl/comparador_serie_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   - FSM state encoding (IDLE / COMPARA / FIN)
//   - one-hot result codes in {igual,mayor,menor} order
//   - flags_t: packed view of the cascade flags
package comparador_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARA = 2'd1;
  localparam logic [1:0] ST_FIN     = 2'd2;

  localparam logic [2:0] RES_IGUAL = 3'b100;
  localparam logic [2:0] RES_MAYOR = 3'b010;
  localparam logic [2:0] RES_MENOR = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COMPARA = ST_COMPARA,
    S_FIN     = ST_FIN
  } state_t;

  typedef struct packed {
    logic igual;
    logic mayor;
    logic menor;
  } flags_t;

endpackage

// File: rtl/comparador_serie_if.sv
// Operand/result bundle of the serial comparator.
//   start_i, a_i, b_i        : request side (driven by the master)
//   busy_o, done_o           : status
//   igual_o, mayor_o, menor_o: one-hot result, held between done pulses
interface comparador_serie_if #(
  parameter int N = 8
);
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic         igual_o;
  logic         mayor_o;
  logic         menor_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, igual_o, mayor_o, menor_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, igual_o, mayor_o, menor_o
  );
endinterface

// File: rtl/comparador_serie_cell.sv
// comparador1bit: one cascaded 1-bit magnitude comparator cell.
//   a, b                      : current operand bits
//   igual_i, mayor_i, menor_i : cascade flags from the more significant bits
//   igual_o, mayor_o, menor_o : updated cascade flags
// Once a decision is made (igual_i=0) the flags pass through unchanged.
module comparador1bit (
  input  logic a,
  input  logic b,
  input  logic igual_i,
  input  logic mayor_i,
  input  logic menor_i,
  output logic igual_o,
  output logic mayor_o,
  output logic menor_o
);
  assign igual_o = igual_i & (a ~^ b);
  assign mayor_o = mayor_i | (igual_i & a & ~b);
  assign menor_o = menor_i | (igual_i & ~a & b);
endmodule

// File: rtl/comparador_serie.sv
// comparador_serie: bit-serial N-bit magnitude comparator.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of comparador_serie_if (start/operands in,
//           busy/done/one-hot result out)
// Operands are captured on start, then fed MSB-first through a single
// comparador1bit whose registered flags loop back as cascade inputs.
// The walk stops at the first differing bit or after N bits.
module comparador_serie
  import comparador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  comparador_serie_if.slave  bus
);
  localparam int CW = $clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   sa_q, sb_q;
  logic [CW-1:0]  cnt_q;
  flags_t         flags_q, cell_out, res_q;

  comparador1bit u_cell (
    .a       (sa_q[N-1]),
    .b       (sb_q[N-1]),
    .igual_i (flags_q.igual),
    .mayor_i (flags_q.mayor),
    .menor_i (flags_q.menor),
    .igual_o (cell_out.igual),
    .mayor_o (cell_out.mayor),
    .menor_o (cell_out.menor)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start_i) state_d = S_COMPARA;
      S_COMPARA: if (cnt_q == '0 || !cell_out.igual) state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (bus.start_i) begin
          sa_q    <= bus.a_i;
          sb_q    <= bus.b_i;
          flags_q <= flags_t'(RES_IGUAL);
          cnt_q   <= CW'(N - 1);
        end
        S_COMPARA: begin
          flags_q <= cell_out;
          sa_q    <= sa_q << 1;
          sb_q    <= sb_q << 1;
          cnt_q   <= cnt_q - CW'(1);
          // Results are loaded on the edge into FIN so they change
          // exactly in the cycle done_o is high.
          if (state_d == S_FIN) res_q <= cell_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o  = (state_q == S_COMPARA) || (state_q == S_FIN);
  assign bus.done_o  = (state_q == S_FIN);
  assign bus.igual_o = res_q.igual;
  assign bus.mayor_o = res_q.mayor;
  assign bus.menor_o = res_q.menor;
endmodule
